circular_buffer_queue: RTL and testbench

Parametrised single-clock queue on a circular buffer with read/write pointers, so data is never shifted. It adds occupancy count, programmable almost-full/almost-empty flags, synchronous flush and a sticky overflow flag. It keeps the push/pop back-pressure convention used by the memory library. It sits between streaming producers and consumers wherever buffering deeper than a few entries, or with level visibility, is needed.

---
 rtl/circular_buffer_queue_pkg.sv | 12 +
 rtl/circular_buffer_queue_ram.sv | 33 +++
 rtl/circular_buffer_queue.sv | 132 +++++++++++++
 tb/tb_circular_buffer_queue.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/circular_buffer_queue_pkg.sv
// Shared definitions for the circular buffer queue.
//   queue_state_t : occupancy state of the queue controller
//   width_for()   : clog2-based width helper, never returns less than 1 bit
package queue_pkg;

    typedef enum logic [1:0] {Q_EMPTY, Q_PARTIAL, Q_FULL} queue_state_t;

    function automatic int width_for(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/circular_buffer_queue_ram.sv
// Queue storage: DATA_WIDTH x QUEUE_DEPTH, synchronous write, asynchronous read.
// Kept separate so a vendor RAM can replace it without touching the control logic.
// Ports:
//   clock        in   write clock (rising edge)
//   write_enable in   write write_data into write_addr this edge
//   write_addr   in   write address
//   write_data   in   write data
//   read_addr    in   read address
//   read_data    out  mem[read_addr], combinational
module queue_ram #(
    parameter int DATA_WIDTH  = 8,
    parameter int QUEUE_DEPTH = 10,
    parameter int ADDR_WIDTH  = 4
) (
    input  logic                  clock,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] read_data
);

    logic [DATA_WIDTH-1:0] mem [QUEUE_DEPTH];

    always_ff @(posedge clock) begin
        if (write_enable) begin
            mem[write_addr] <= write_data;
        end
    end

    assign read_data = mem[read_addr];

endmodule

// File: rtl/circular_buffer_queue.sv
// Single-clock FIFO queue on a circular buffer with occupancy count,
// almost-full/almost-empty flags, synchronous flush and sticky overflow.
// Ports:
//   clock             in   rising-edge clock
//   resetN            in   asynchronous active-low reset
//   flush             in   synchronous clear of contents (priority over push/pop)
//   in_data/in_valid  in   item to push and its valid
//   in_back_pressure  out  1 = queue full, push refused
//   out_data          out  item at queue front (first-word-fall-through)
//   out_valid         out  1 = out_data holds a valid item
//   out_back_pressure in   1 = receiver not ready
//   count             out  current occupancy
//   almost_full       out  count >= ALMOST_FULL_LEVEL
//   almost_empty      out  count <= ALMOST_EMPTY_LEVEL
//   overflow          out  sticky: push attempted while full
module circular_buffer_queue
    import queue_pkg::*;
#(
    parameter int DATA_WIDTH         = 8,
    parameter int QUEUE_DEPTH        = 10,
    parameter int ALMOST_FULL_LEVEL  = QUEUE_DEPTH - 2,
    parameter int ALMOST_EMPTY_LEVEL = 2,
    localparam int ADDR_WIDTH        = width_for(QUEUE_DEPTH),
    localparam int COUNT_WIDTH       = width_for(QUEUE_DEPTH + 1)
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic                   flush,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    output logic                   in_back_pressure,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    input  logic                   out_back_pressure,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic                   overflow
);

    localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR     = ADDR_WIDTH'(QUEUE_DEPTH - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE     = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_LAST    = COUNT_WIDTH'(QUEUE_DEPTH - 1);
    localparam logic [COUNT_WIDTH-1:0] AF_LEVEL      = COUNT_WIDTH'(ALMOST_FULL_LEVEL);
    localparam logic [COUNT_WIDTH-1:0] AE_LEVEL      = COUNT_WIDTH'(ALMOST_EMPTY_LEVEL);

    queue_state_t          state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  push;
    logic                  pop;

    // Depth need not be a power of two, so wrap on an explicit compare.
    function automatic logic [ADDR_WIDTH-1:0] advance(input logic [ADDR_WIDTH-1:0] ptr);
        return (ptr == LAST_ADDR) ? '0 : ptr + 1'b1;
    endfunction

    // Status is decoded from registered state only; FULL refuses a push even
    // when a pop happens in the same cycle.
    assign out_valid        = (state != Q_EMPTY);
    assign in_back_pressure = (state == Q_FULL);
    assign almost_full      = (count >= AF_LEVEL);
    assign almost_empty     = (count <= AE_LEVEL);

    assign push = in_valid & ~in_back_pressure;
    assign pop  = out_valid & ~out_back_pressure;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state    <= Q_EMPTY;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            state    <= Q_EMPTY;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= advance(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= advance(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (in_valid && (state == Q_FULL)) begin
                overflow <= 1'b1;
            end
            case (state)
                Q_EMPTY: begin
                    if (push) begin
                        state <= Q_PARTIAL;
                    end
                end
                Q_PARTIAL: begin
                    if (push && !pop && (count == COUNT_LAST)) begin
                        state <= Q_FULL;
                    end else if (pop && !push && (count == COUNT_ONE)) begin
                        state <= Q_EMPTY;
                    end
                end
                Q_FULL: begin
                    if (pop) begin
                        state <= Q_PARTIAL;
                    end
                end
                default: state <= Q_EMPTY;
            endcase
        end
    end

    queue_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .QUEUE_DEPTH(QUEUE_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clock       (clock),
        .write_enable(push & ~flush),
        .write_addr  (wr_ptr),
        .write_data  (in_data),
        .read_addr   (rd_ptr),
        .read_data   (out_data)
    );

endmodule

// File: tb/tb_circular_buffer_queue.sv
// Self-checking bench for circular_buffer_queue (depth 5, AF 4, AE 1, 8-bit data).
module tb_circular_buffer_queue;

    localparam int DW    = 8;
    localparam int DEPTH = 5;
    localparam int AF    = 4;
    localparam int AE    = 1;

    logic          clock = 1'b0;
    logic          resetN = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_back_pressure;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_back_pressure = 1'b0;
    logic [2:0]    count;
    logic          almost_full;
    logic          almost_empty;
    logic          overflow;

    circular_buffer_queue #(
        .DATA_WIDTH        (DW),
        .QUEUE_DEPTH       (DEPTH),
        .ALMOST_FULL_LEVEL (AF),
        .ALMOST_EMPTY_LEVEL(AE)
    ) dut (
        .clock            (clock),
        .resetN           (resetN),
        .flush            (flush),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_back_pressure (in_back_pressure),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_back_pressure(out_back_pressure),
        .count            (count),
        .almost_full      (almost_full),
        .almost_empty     (almost_empty),
        .overflow         (overflow)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a plain FIFO of items plus the sticky overflow bit.
    logic [DW-1:0] mq[$];
    bit            m_ovf = 1'b0;

    typedef struct {
        logic          f;
        logic          iv;
        logic [DW-1:0] d;
        logic          obp;
        int            cnt;
        logic          ov;
        logic [DW-1:0] data;
        logic          bp;
        logic          af;
        logic          ae;
        logic          ovf;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic model_update(input logic f, input logic iv, input logic [DW-1:0] d,
                                input logic obp);
        bit full;
        bit nonempty;
        if (f) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            full     = (mq.size() == DEPTH);
            nonempty = (mq.size() != 0);
            if (iv && full) m_ovf = 1'b1;
            if (nonempty && !obp) void'(mq.pop_front());
            if (iv && !full) mq.push_back(d);
        end
    endtask

    // Drive one cycle of inputs, clock it, advance the model, settle.
    task automatic step(input logic f, input logic iv, input logic [DW-1:0] d, input logic obp);
        flush             = f;
        in_valid          = iv;
        in_data           = d;
        out_back_pressure = obp;
        @(posedge clock);
        model_update(f, iv, d, obp);
        #1;
    endtask

    task automatic check_model(input string tag);
        int sz;
        sz = mq.size();
        check({tag, " count"}, int'(count), sz);
        check({tag, " out_valid"}, int'(out_valid), int'(sz > 0));
        check({tag, " in_back_pressure"}, int'(in_back_pressure), int'(sz == DEPTH));
        check({tag, " almost_full"}, int'(almost_full), int'(sz >= AF));
        check({tag, " almost_empty"}, int'(almost_empty), int'(sz <= AE));
        check({tag, " overflow"}, int'(overflow), int'(m_ovf));
        if (sz > 0) check({tag, " out_data"}, int'(out_data), int'(mq[0]));
    endtask

    task automatic expect_all(input string tag, input int cnt, input logic ov,
                              input logic [DW-1:0] data, input logic bp, input logic af,
                              input logic ae, input logic ovf);
        check({tag, " count"}, int'(count), cnt);
        check({tag, " out_valid"}, int'(out_valid), int'(ov));
        check({tag, " in_back_pressure"}, int'(in_back_pressure), int'(bp));
        check({tag, " almost_full"}, int'(almost_full), int'(af));
        check({tag, " almost_empty"}, int'(almost_empty), int'(ae));
        check({tag, " overflow"}, int'(overflow), int'(ovf));
        if (ov) check({tag, " out_data"}, int'(out_data), int'(data));
    endtask

    // Asynchronous assertion is checked before any clock edge can act on it.
    task automatic do_reset(input string tag);
        flush = 1'b0; in_valid = 1'b0; in_data = '0; out_back_pressure = 1'b0;
        resetN = 1'b0;
        #2;
        expect_all({tag, " reset"}, 0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clock);
        resetN = 1'b1;
        @(posedge clock);
        #1;
        mq.delete();
        m_ovf = 1'b0;
    endtask

    initial begin
        @(posedge clock);
        #1;
        do_reset("init");

        // First push: visible one cycle later, fall-through.
        step(1'b0, 1'b1, 8'h11, 1'b1);
        expect_all("first_push", 1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 8'h12, 1'b1);
        do_reset("midop");

        // Fill to full, overflow, then drain in order.
        tbl[0]  = '{1'b0, 1'b1, 8'h01, 1'b1, 1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 8'h02, 1'b1, 2, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 8'h03, 1'b1, 3, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 8'h04, 1'b1, 4, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 8'h05, 1'b1, 5, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 8'h06, 1'b1, 5, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 4, 1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 3, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 2, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1, 1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].f, tbl[i].iv, tbl[i].d, tbl[i].obp);
            expect_all($sformatf("tbl%0d", i), tbl[i].cnt, tbl[i].ov, tbl[i].data,
                       tbl[i].bp, tbl[i].af, tbl[i].ae, tbl[i].ovf);
        end

        // Simultaneous push and pop at count 2.
        do_reset("pp");
        step(1'b0, 1'b1, 8'hA0, 1'b1);
        step(1'b0, 1'b1, 8'hA1, 1'b1);
        step(1'b0, 1'b1, 8'hA2, 1'b0);
        expect_all("pushpop", 2, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        expect_all("pushpop_next", 1, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b0);

        // Flush with a concurrent push at count 3, overflow set.
        do_reset("fl");
        for (int i = 1; i <= 6; i++) step(1'b0, 1'b1, 8'(i), 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        expect_all("pre_flush", 3, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'h77, 1'b1);
        expect_all("flush", 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        expect_all("post_flush", 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

        // Full: pop with in_valid refuses the push.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h21 + i), 1'b1);
        expect_all("full", 5, 1'b1, 8'h21, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h26, 1'b0);
        expect_all("full_pop_push", 4, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0);
            check_model($sformatf("drain%0d", i));
        end

        // Streaming across pointer wrap with alternating back-pressure.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 8'(8'h40 + i), ((i % 2) == 0));
            check_model($sformatf("stream%0d", i));
            check($sformatf("stream%0d count_le_depth", i), int'(count <= 3'(DEPTH)), 1);
        end
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0);
            check_model($sformatf("sdrain%0d", i));
        end

        // Randomised traffic against the model, biased towards full then empty.
        for (int i = 0; i < 600; i++) begin
            int obp_pct;
            obp_pct = (i < 300) ? 65 : 25;
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 99) < 70),
                 8'($urandom), ($urandom_range(0, 99) < obp_pct));
            check_model($sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
